// File: rtl/val2_pkg.sv
// Shared definitions for the register-specified Val2 shift sequencer:
// shift encodings, FSM states, count clamps and the effective-count rule.
package val2_pkg;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   localparam logic [5:0] LSL_LSR_CLAMP = 6'd33;
   localparam logic [5:0] ASR_CLAMP     = 6'd32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   // Clamped amounts shift out far enough that stepwise shifting reproduces
   // the ARM saturating results (zero / sign fill and the matching carry).
   function automatic logic [5:0] eff_count(input logic [7:0] amt, input logic [1:0] ty);
      logic [5:0] e;
      e = '0;
      if (amt != 8'd0) begin
         case (ty)
            SH_LSL, SH_LSR: e = (amt > 8'd33) ? LSL_LSR_CLAMP : amt[5:0];
            SH_ASR:         e = (amt > 8'd32) ? ASR_CLAMP : amt[5:0];
            default:        e = (amt[4:0] == 5'd0) ? 6'd32 : {1'b0, amt[4:0]};
         endcase
      end
      return e;
   endfunction

endpackage

// File: rtl/val2_shift_step.sv
// One combinational shift step of k bits (k <= STEP) with ARM-style carry-out.
module val2_shift_step
   import val2_pkg::*;
(
   input  logic [31:0] i_data,
   input  logic [1:0]  i_type,
   input  logic [3:0]  i_k,
   output logic [31:0] o_data,
   output logic        o_carry
);

   logic [4:0] w_lidx;
   logic [4:0] w_ridx;
   logic [5:0] w_kk;

   always_comb begin
      w_kk    = {2'b00, i_k};
      w_lidx  = 5'(6'd32 - w_kk);
      w_ridx  = 5'(w_kk - 6'd1);
      o_data  = i_data;
      o_carry = 1'b0;
      if (i_k != 4'd0) begin
         case (i_type)
            SH_LSL: begin
               o_data  = i_data << i_k;
               o_carry = i_data[w_lidx];
            end
            SH_LSR: begin
               o_data  = i_data >> i_k;
               o_carry = i_data[w_ridx];
            end
            SH_ASR: begin
               o_data  = $unsigned($signed(i_data) >>> i_k);
               o_carry = i_data[w_ridx];
            end
            default: begin
               o_data  = (i_data >> i_k) | (i_data << (6'd32 - w_kk));
               o_carry = i_data[w_ridx];
            end
         endcase
      end
   end

endmodule

// File: rtl/val2_shift_sequencer.sv
// Multi-cycle shifter for register-specified shift amounts: shifts STEP bits
// per cycle, stalls the pipeline while busy, returns val_2 and shifter carry.
module val2_shift_sequencer
   import val2_pkg::*;
#(
   parameter int unsigned STEP  = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] rm,
   input  logic [7:0]       rs_amt,
   input  logic [1:0]       shift_type,
   input  logic             carry_in,
   output logic             ready,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] val_2,
   output logic             shift_carry
);

   state_t      r_state;
   logic [5:0]  r_rem;
   logic [31:0] r_data;
   logic [1:0]  r_type;
   logic [31:0] r_val2;
   logic        r_carry;
   logic        r_done;

   logic [5:0]  w_eff;
   logic [3:0]  w_k;
   logic        w_last;
   logic [31:0] w_step_data;
   logic        w_step_carry;

   always_comb begin
      w_eff  = eff_count(rs_amt, shift_type);
      w_k    = (r_rem < 6'(STEP)) ? r_rem[3:0] : 4'(STEP);
      w_last = (r_rem <= 6'(STEP));
   end

   val2_shift_step u_step (
      .i_data  (r_data),
      .i_type  (r_type),
      .i_k     (w_k),
      .o_data  (w_step_data),
      .o_carry (w_step_carry)
   );

   // Result registers update only on completion so a flush leaves the
   // last completed val_2/shift_carry visible to the pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rem   <= '0;
         r_data  <= '0;
         r_type  <= SH_LSL;
         r_val2  <= '0;
         r_carry <= 1'b0;
         r_done  <= 1'b0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_rem   <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_data <= rm;
                  r_type <= shift_type;
                  if (w_eff == 6'd0) begin
                     r_val2  <= rm;
                     r_carry <= carry_in;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_rem   <= w_eff;
                     r_state <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               r_data <= w_step_data;
               r_rem  <= r_rem - 6'(w_k);
               if (w_last) begin
                  r_val2  <= w_step_data;
                  r_carry <= w_step_carry;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready       = (r_state == S_IDLE);
   assign stall       = (r_state == S_SHIFT) ||
                        ((r_state == S_IDLE) && start && !flush && (w_eff != 6'd0));
   assign done        = r_done;
   assign val_2       = r_val2;
   assign shift_carry = r_carry;

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Scoreboard bench for val2_shift_sequencer against an ARM barrel-shifter model.
module tb_val2_shift_sequencer;

   localparam int unsigned STEP = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic        flush;
   logic [31:0] rm;
   logic [7:0]  rs_amt;
   logic [1:0]  shift_type;
   logic        carry_in;
   logic        ready;
   logic        stall;
   logic        done;
   logic [31:0] val_2;
   logic        shift_carry;

   typedef struct {
      logic [31:0] val;
      logic        carry;
      int          cyc;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          total;
   int          bad;
   int          cyc;
   logic [31:0] last_val;
   logic        last_carry;

   val2_shift_sequencer #(.STEP(STEP), .WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .flush       (flush),
      .rm          (rm),
      .rs_amt      (rs_amt),
      .shift_type  (shift_type),
      .carry_in    (carry_in),
      .ready       (ready),
      .stall       (stall),
      .done        (done),
      .val_2       (val_2),
      .shift_carry (shift_carry)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ARM register-shift semantics written directly from the shift rules.
   function automatic void ref_shift(input logic [31:0] a, input logic [7:0] amt,
                                     input logic [1:0] ty, input logic cin,
                                     output logic [31:0] v, output logic c);
      int unsigned n;
      int unsigned r;
      n = amt;
      r = n % 32;
      v = a;
      c = cin;
      if (n != 0) begin
         case (ty)
            2'b00: begin
               if (n < 32)       begin v = a << n; c = a[32 - n]; end
               else if (n == 32) begin v = '0; c = a[0]; end
               else              begin v = '0; c = 1'b0; end
            end
            2'b01: begin
               if (n < 32)       begin v = a >> n; c = a[n - 1]; end
               else if (n == 32) begin v = '0; c = a[31]; end
               else              begin v = '0; c = 1'b0; end
            end
            2'b10: begin
               if (n < 32) begin v = $signed(a) >>> n; c = a[n - 1]; end
               else        begin v = {32{a[31]}}; c = a[31]; end
            end
            default: begin
               if (r == 0) begin v = a; c = a[31]; end
               else        begin v = (a >> r) | (a << (32 - r)); c = a[r - 1]; end
            end
         endcase
      end
   endfunction

   function automatic int ref_eff(input logic [7:0] amt, input logic [1:0] ty);
      int n;
      n = amt;
      if (n == 0) return 0;
      case (ty)
         2'b00, 2'b01: return (n > 33) ? 33 : n;
         2'b10:        return (n > 32) ? 32 : n;
         default:      return ((n % 32) == 0) ? 32 : (n % 32);
      endcase
   endfunction

   task automatic scramble();
      rm         = $urandom;
      rs_amt     = 8'($urandom);
      shift_type = 2'($urandom);
      carry_in   = 1'($urandom);
      start      = 1'($urandom_range(0, 1));
   endtask

   // Runs one full transaction starting at a negedge where the DUT is idle.
   task automatic run_txn(input logic [31:0] a_rm, input logic [7:0] a_amt,
                          input logic [1:0] a_ty, input logic a_cin);
      exp_t e;
      int   eff;
      int   nsh;
      ref_shift(a_rm, a_amt, a_ty, a_cin, e.val, e.carry);
      eff   = ref_eff(a_amt, a_ty);
      nsh   = (eff + int'(STEP) - 1) / int'(STEP);
      e.lat = 1 + nsh;
      e.cyc = cyc;
      check("ready_idle", 32'(ready), 32'd1);
      rm = a_rm; rs_amt = a_amt; shift_type = a_ty; carry_in = a_cin; start = 1'b1;
      sb.push_back(e);
      #1 check("stall_start", 32'(stall), 32'(eff != 0));
      for (int i = 0; i < nsh; i++) begin
         @(negedge clk);
         scramble();
         #1 check("stall_shift", 32'(stall), 32'd1);
      end
      @(negedge clk);
      scramble();
      #1 check("stall_done", 32'(stall), 32'd0);
      check("ready_done", 32'(ready), 32'd0);
      @(negedge clk);
      start      = 1'b0;
      last_val   = e.val;
      last_carry = e.carry;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 expected no pending result");
         end else begin
            e = sb.pop_front();
            check("val_2", val_2, e.val);
            check("shift_carry", 32'(shift_carry), 32'(e.carry));
            check("latency", 32'(cyc - e.cyc), 32'(e.lat));
         end
      end
   end

   initial begin
      total = 0; bad = 0; cyc = 0;
      last_val = '0; last_carry = 1'b0;
      rst = 1'b1; start = 1'b0; flush = 1'b0;
      rm = '0; rs_amt = '0; shift_type = '0; carry_in = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_val_2", val_2, 32'd0);
      check("rst_carry", 32'(shift_carry), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_txn(32'h0000_0001, 8'd4,   2'b00, 1'b0);
      run_txn(32'h8000_0000, 8'd32,  2'b01, 1'b0);
      run_txn(32'h8000_0000, 8'd40,  2'b01, 1'b1);
      run_txn(32'h8000_0000, 8'd200, 2'b10, 1'b0);
      run_txn(32'h8000_0001, 8'd32,  2'b11, 1'b0);
      run_txn(32'h8000_0001, 8'd1,   2'b11, 1'b0);
      run_txn(32'h1234_5678, 8'd0,   2'b10, 1'b1);
      run_txn(32'h0000_0003, 8'd32,  2'b00, 1'b0);
      run_txn(32'hFFFF_FFFF, 8'd33,  2'b00, 1'b1);
      run_txn(32'h4000_0000, 8'd31,  2'b10, 1'b0);

      for (int t = 0; t < 200; t++) begin
         logic [7:0] amt;
         amt = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
         run_txn($urandom, amt, 2'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      // Flush in the second SHIFT cycle of a 16-bit shift; start mid-shift is ignored.
      rm = 32'hDEAD_BEEF; rs_amt = 8'd16; shift_type = 2'b00; carry_in = 1'b1; start = 1'b1;
      @(negedge clk);
      rm = 32'h0000_00FF; rs_amt = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1 check("flush_ready", 32'(ready), 32'd1);
      check("flush_done", 32'(done), 32'd0);
      check("flush_val_2", val_2, last_val);
      check("flush_carry", 32'(shift_carry), 32'(last_carry));
      repeat (12) @(negedge clk);
      check("flush_hold_val_2", val_2, last_val);

      // Flush and start together: request dropped.
      rm = 32'h0000_0010; rs_amt = 8'd0; carry_in = 1'b1; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1 check("flush_start_ready", 32'(ready), 32'd1);
      repeat (3) @(negedge clk);
      check("flush_start_val_2", val_2, last_val);

      run_txn(32'hCAFE_F00D, 8'd5, 2'b01, 1'b0);

      // Asynchronous reset mid-SHIFT.
      rm = 32'hFFFF_0000; rs_amt = 8'd20; shift_type = 2'b10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1 check("rst_mid_ready", 32'(ready), 32'd1);
      check("rst_mid_stall", 32'(stall), 32'd0);
      check("rst_mid_val_2", val_2, 32'd0);
      check("rst_mid_carry", 32'(shift_carry), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_val = '0; last_carry = 1'b0;
      repeat (12) @(negedge clk);
      check("rst_mid_no_done_val_2", val_2, 32'd0);

      run_txn(32'h0F0F_0F0F, 8'd8, 2'b11, 1'b0);

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
